// File: rtl/uart_rx.sv
// 8N1 serial receiver, LSB first. Two-flop line synchroniser, mid-bit start
// qualification, stop-bit check, registered valid / frame_err strobes.
module uart_rx #(
    parameter logic [9:0] BAUD_DIVISOR = 10'd868
) (
    input  logic       clk100,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_HIGH = 3'd4
    } state_t;

    localparam logic [9:0] HALF_BIT = BAUD_DIVISOR >> 1;

    logic       r_rx_meta;
    logic       r_rx_s;
    state_t     r_state;
    logic [9:0] r_timer;
    logic [2:0] r_bit_idx;
    logic [7:0] r_shift;
    logic [7:0] r_data;
    logic       r_valid;
    logic       r_frame_err;

    state_t     w_state_nxt;
    logic [9:0] w_timer_nxt;
    logic [2:0] w_bit_idx_nxt;
    logic [7:0] w_shift_nxt;
    logic       w_load_data;
    logic       w_valid_nxt;
    logic       w_frame_err_nxt;
    logic       w_timer_zero;

    // Synchroniser resets to the idle (high) level so reset never looks like a start edge.
    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_timer     <= 10'd0;
            r_bit_idx   <= 3'd0;
            r_shift     <= 8'h00;
            r_data      <= 8'h00;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_timer     <= w_timer_nxt;
            r_bit_idx   <= w_bit_idx_nxt;
            r_shift     <= w_shift_nxt;
            r_valid     <= w_valid_nxt;
            r_frame_err <= w_frame_err_nxt;
            if (w_load_data) begin
                r_data <= r_shift;
            end
        end
    end

    assign w_timer_zero = (r_timer == 10'd0);

    always_comb begin
        w_state_nxt     = r_state;
        w_timer_nxt     = w_timer_zero ? r_timer : r_timer - 10'd1;
        w_bit_idx_nxt   = r_bit_idx;
        w_shift_nxt     = r_shift;
        w_load_data     = 1'b0;
        w_valid_nxt     = 1'b0;
        w_frame_err_nxt = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (!r_rx_s) begin
                    w_state_nxt = S_START;
                    w_timer_nxt = HALF_BIT;
                end
            end
            S_START: begin
                // A line that is high again at mid-bit was only a glitch.
                if (w_timer_zero) begin
                    if (!r_rx_s) begin
                        w_state_nxt   = S_DATA;
                        w_timer_nxt   = BAUD_DIVISOR;
                        w_bit_idx_nxt = 3'd0;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (w_timer_zero) begin
                    w_shift_nxt   = {r_rx_s, r_shift[7:1]};
                    w_timer_nxt   = BAUD_DIVISOR;
                    w_bit_idx_nxt = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (w_timer_zero) begin
                    w_load_data = 1'b1;
                    if (r_rx_s) begin
                        w_valid_nxt = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_frame_err_nxt = 1'b1;
                        w_state_nxt     = S_WAIT_HIGH;
                    end
                end
            end
            S_WAIT_HIGH: begin
                // Absorb a break so it reports one framing error, not a stream.
                if (r_rx_s) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign data      = r_data;
    assign valid     = r_valid;
    assign frame_err = r_frame_err;
    assign busy      = (r_state != S_IDLE);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at a 16-clock bit: byte streams, glitch, break,
// mid-frame reset and sender skew, checked against a frame-level model.
module tb_uart_rx;

  localparam int BIT = 16;
  // Clocks from the first edge that sees the start bit to the edge that samples the stop bit.
  localparam int STROBE_LAT = 155;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;
  logic [2:0] dbg_state;

  int n_cmp = 0;
  int n_fail = 0;
  int n_valid = 0;
  int n_ferr = 0;
  int cyc = 0;

  logic [7:0] exp_q[$];
  logic       exp_err_q[$];
  int         exp_cyc_q[$];
  logic [7:0] model_data = 8'h00;

  uart_rx #(.BAUD_DIVISOR(10'd15)) dut (
    .clk100    (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Drives one frame of period p; stop level is left on the line afterwards.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int p, input bit expect_it);
    if (expect_it) begin
      exp_q.push_back(b);
      exp_err_q.push_back(!stop);
      exp_cyc_q.push_back(cyc + STROBE_LAT);
    end
    rx = 1'b0;
    wait_cyc(p);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_cyc(p);
    end
    rx = stop;
    wait_cyc(p);
  endtask

  // scoreboard: strobes only at model-predicted cycles, data held otherwise
  always @(negedge clk) begin
    if (!rst_n) begin
      model_data = 8'h00;
    end else begin
      chk("strobe_mutex", {31'd0, valid & frame_err}, 32'd0);
      if (exp_cyc_q.size() != 0 && cyc == exp_cyc_q[0]) begin
        chk("strobe_present", {31'd0, valid | frame_err}, 32'd1);
        chk("strobe_kind_err", {31'd0, frame_err}, {31'd0, exp_err_q[0]});
        chk("strobe_data", {24'd0, data}, {24'd0, exp_q[0]});
        model_data = exp_q[0];
        void'(exp_q.pop_front());
        void'(exp_err_q.pop_front());
        void'(exp_cyc_q.pop_front());
      end else begin
        chk("no_strobe", {30'd0, valid, frame_err}, 32'd0);
        chk("data_hold", {24'd0, data}, {24'd0, model_data});
      end
      if (valid) n_valid++;
      if (frame_err) n_ferr++;
    end
  end

  initial begin
    rx = 1'b1;
    rst_n = 1'b0;
    wait_cyc(3);
    chk("rst_data", {24'd0, data}, 32'h00);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_ferr", {31'd0, frame_err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_state", {29'd0, dbg_state}, 32'd0);
    rst_n = 1'b1;
    wait_cyc(3);

    // back-to-back 0x55, 0xA3
    send_frame(8'h55, 1'b1, BIT, 1'b1);
    send_frame(8'hA3, 1'b1, BIT, 1'b1);
    wait_cyc(20);
    chk("t1_data", {24'd0, data}, 32'hA3);
    chk("t1_nvalid", n_valid, 32'd2);

    // all byte values back-to-back
    for (int i = 0; i < 256; i++) begin
      logic [7:0] b;
      b = i[7:0];
      send_frame(b, 1'b1, BIT, 1'b1);
    end
    wait_cyc(20);
    chk("t2_nvalid", n_valid, 32'd258);
    chk("t2_data", {24'd0, data}, 32'hFF);

    // 5-clock start glitch
    rx = 1'b0;
    wait_cyc(2);
    chk("t3_busy_pre", {31'd0, busy}, 32'd0);
    wait_cyc(1);
    chk("t3_busy_rise", {31'd0, busy}, 32'd1);
    wait_cyc(2);
    rx = 1'b1;
    wait_cyc(5);
    chk("t3_busy_hold", {31'd0, busy}, 32'd1);
    wait_cyc(1);
    chk("t3_busy_fall", {31'd0, busy}, 32'd0);
    chk("t3_state_idle", {29'd0, dbg_state}, 32'd0);
    wait_cyc(20);
    send_frame(8'h3C, 1'b1, BIT, 1'b1);
    wait_cyc(20);
    chk("t3_data", {24'd0, data}, 32'h3C);

    // framing error followed by a 40-bit break
    send_frame(8'h81, 1'b0, BIT, 1'b1);
    for (int k = 0; k < 4; k++) begin
      wait_cyc(10 * BIT);
      chk("t4_state_wait_high", {29'd0, dbg_state}, 32'd4);
      chk("t4_busy", {31'd0, busy}, 32'd1);
    end
    chk("t4_data", {24'd0, data}, 32'h81);
    rx = 1'b1;
    wait_cyc(5);
    chk("t4_state_idle", {29'd0, dbg_state}, 32'd0);
    chk("t4_nferr", n_ferr, 32'd1);
    wait_cyc(20);
    send_frame(8'h42, 1'b1, BIT, 1'b1);
    wait_cyc(20);
    chk("t4_next_data", {24'd0, data}, 32'h42);

    // reset during bit 4 of 0xFF
    fork
      send_frame(8'hFF, 1'b1, BIT, 1'b0);
      begin
        repeat (72) @(posedge clk);
        #4;
        chk("t5_busy_pre", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_data", {24'd0, data}, 32'h00);
        chk("t5_rst_valid", {31'd0, valid}, 32'd0);
        chk("t5_rst_ferr", {31'd0, frame_err}, 32'd0);
        chk("t5_rst_busy", {31'd0, busy}, 32'd0);
        chk("t5_rst_state", {29'd0, dbg_state}, 32'd0);
        repeat (3) @(posedge clk);
        #4;
        rst_n = 1'b1;
      end
    join
    wait_cyc(20);
    send_frame(8'h12, 1'b1, BIT, 1'b1);
    wait_cyc(20);
    chk("t5_data", {24'd0, data}, 32'h12);

    // sender bit period skewed to 15 and 17 clocks
    send_frame(8'hC6, 1'b1, 15, 1'b1);
    wait_cyc(30);
    chk("t6_fast_data", {24'd0, data}, 32'hC6);
    send_frame(8'hC6, 1'b1, 17, 1'b1);
    wait_cyc(30);
    chk("t6_slow_data", {24'd0, data}, 32'hC6);

    chk("final_nvalid", n_valid, 32'd263);
    chk("final_nferr", n_ferr, 32'd1);
    chk("final_queue_empty", exp_cyc_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
